// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO peripheral responder.
package mmio_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned OFF_W   = 5;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned TCON_W  = 3;
   localparam int unsigned PC_W    = 16;
   localparam int unsigned LED_W   = 8;
   localparam int unsigned DIG_W   = 12;

   // Default start of the 32-byte register window.
   localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

   // Byte offsets of the registers inside the window.
   localparam logic [OFF_W-1:0] OFF_TH      = 5'h00;
   localparam logic [OFF_W-1:0] OFF_TL      = 5'h04;
   localparam logic [OFF_W-1:0] OFF_TCON    = 5'h08;
   localparam logic [OFF_W-1:0] OFF_LED     = 5'h0C;
   localparam logic [OFF_W-1:0] OFF_DIGITS  = 5'h10;
   localparam logic [OFF_W-1:0] OFF_SYSTICK = 5'h14;

   // Word indices (Address[4:2]) derived from the byte offsets.
   localparam logic [IDX_W-1:0] IDX_TH      = IDX_W'(OFF_TH      >> 2);
   localparam logic [IDX_W-1:0] IDX_TL      = IDX_W'(OFF_TL      >> 2);
   localparam logic [IDX_W-1:0] IDX_TCON    = IDX_W'(OFF_TCON    >> 2);
   localparam logic [IDX_W-1:0] IDX_LED     = IDX_W'(OFF_LED     >> 2);
   localparam logic [IDX_W-1:0] IDX_DIGITS  = IDX_W'(OFF_DIGITS  >> 2);
   localparam logic [IDX_W-1:0] IDX_SYSTICK = IDX_W'(OFF_SYSTICK >> 2);

   // TCON bit positions.
   localparam int unsigned TCON_EN = 0;
   localparam int unsigned TCON_IE = 1;
   localparam int unsigned TCON_IF = 2;

   // Timer operating mode, decoded from TCON enable.
   typedef enum logic {
      T_IDLE = 1'b0,
      T_RUN  = 1'b1
   } timer_state_e;

   // Decoded CPU write strobes and data towards the timer core.
   typedef struct packed {
      logic              th_we;
      logic              tl_we;
      logic              tcon_we;
      logic [DATA_W-1:0] wdata;
   } timer_wr_t;

endpackage

// File: rtl/mmio_timer_core.sv
// Reloadable timer: prescaler, TL/TH update and overflow status flag.
module mmio_timer_core
   import mmio_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  timer_wr_t         wr_i,
   output logic [DATA_W-1:0] th_o,
   output logic [DATA_W-1:0] tl_o,
   output logic [TCON_W-1:0] tcon_o
);

   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

   logic [PC_W-1:0]   pc_q;
   logic [DATA_W-1:0] th_q;
   logic [DATA_W-1:0] tl_q;
   logic [TCON_W-1:0] tcon_q;

   timer_state_e      state_c;
   logic              tick_c;
   logic              ovf_c;

   // Mode decode, prescaler tick and overflow detect
   always_comb begin
      state_c = tcon_q[TCON_EN] ? T_RUN : T_IDLE;
      tick_c  = (state_c == T_RUN) && (pc_q == PC_LAST);
      ovf_c   = tick_c && (tl_q == '1);
   end

   // Timer state: hardware count/reload first, CPU writes take priority
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q   <= '0;
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         case (state_c)
            T_IDLE: begin
               // Prescaler is frozen, not cleared, while disabled.
               pc_q <= pc_q;
            end
            T_RUN: begin
               pc_q <= tick_c ? '0 : pc_q + PC_W'(1);
               if (tick_c) begin
                  if (ovf_c) begin
                     // Reload from the pre-write TH even if TH is written now.
                     tl_q <= th_q;
                     if (tcon_q[TCON_IE]) begin
                        tcon_q[TCON_IF] <= 1'b1;
                     end
                  end else begin
                     tl_q <= tl_q + DATA_W'(1);
                  end
               end
            end
         endcase

         if (wr_i.th_we) begin
            th_q <= wr_i.wdata;
         end
         if (wr_i.tl_we) begin
            tl_q <= wr_i.wdata;
         end
         if (wr_i.tcon_we) begin
            tcon_q <= wr_i.wdata[TCON_W-1:0];
         end
      end
   end

   assign th_o   = th_q;
   assign tl_o   = tl_q;
   assign tcon_o = tcon_q;

endmodule

// File: rtl/mmio_peripheral_responder.sv
// Memory-mapped timer / systick / LED / seven-segment peripheral on the data bus.
module mmio_peripheral_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_Data,
   output logic [31:0] Read_Data,
   output logic [7:0]  leds,
   output logic [11:0] digits,
   output logic        irq
);

   logic              hit_c;
   logic [IDX_W-1:0]  idx_c;
   logic              wr_c;
   timer_wr_t         timer_wr_c;

   logic [DATA_W-1:0] tmr_th;
   logic [DATA_W-1:0] tmr_tl;
   logic [TCON_W-1:0] tmr_tcon;

   logic [LED_W-1:0]  led_q, led_d;
   logic [DIG_W-1:0]  dig_q, dig_d;
   logic [DATA_W-1:0] systick_q, systick_d;

   logic              unused_addr_lsb;

   // Window hit and word index; byte lanes are ignored on this word-only bus
   always_comb begin
      hit_c = (Address[31:5] == BASE_ADDR[31:5]);
      idx_c = Address[4:2];
      wr_c  = MemWrite && hit_c;
   end

   // Per-register write strobes for the timer core
   always_comb begin
      timer_wr_c         = '0;
      timer_wr_c.wdata   = Write_Data;
      timer_wr_c.th_we   = wr_c && (idx_c == IDX_TH);
      timer_wr_c.tl_we   = wr_c && (idx_c == IDX_TL);
      timer_wr_c.tcon_we = wr_c && (idx_c == IDX_TCON);
   end

   mmio_timer_core #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk    (clk),
      .rst_ni (reset),
      .wr_i   (timer_wr_c),
      .th_o   (tmr_th),
      .tl_o   (tmr_tl),
      .tcon_o (tmr_tcon)
   );

   // Next state of LED, DIGITS and the free-running systick
   always_comb begin
      led_d     = led_q;
      dig_d     = dig_q;
      systick_d = systick_q + DATA_W'(1);
      if (wr_c && (idx_c == IDX_LED)) begin
         led_d = Write_Data[LED_W-1:0];
      end
      if (wr_c && (idx_c == IDX_DIGITS)) begin
         dig_d = Write_Data[DIG_W-1:0];
      end
   end

   // LED, DIGITS and systick registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q     <= '0;
         dig_q     <= '0;
         systick_q <= '0;
      end else begin
         led_q     <= led_d;
         dig_q     <= dig_d;
         systick_q <= systick_d;
      end
   end

   // Zero-latency read mux; shows pre-write values during a read+write cycle
   always_comb begin
      Read_Data = '0;
      if (MemRead && hit_c) begin
         case (idx_c)
            IDX_TH:      Read_Data = tmr_th;
            IDX_TL:      Read_Data = tmr_tl;
            IDX_TCON:    Read_Data = DATA_W'(tmr_tcon);
            IDX_LED:     Read_Data = DATA_W'(led_q);
            IDX_DIGITS:  Read_Data = DATA_W'(dig_q);
            IDX_SYSTICK: Read_Data = systick_q;
            default:     Read_Data = '0;
         endcase
      end
   end

   assign leds   = led_q;
   assign digits = dig_q;
   assign irq    = tmr_tcon[TCON_IE] & tmr_tcon[TCON_IF];

   assign unused_addr_lsb = ^Address[1:0];

endmodule

// File: doc/mmio_peripheral_responder.md
Name: mmio_peripheral_responder

Overview:
- Memory-mapped peripheral that answers the CPU's data-memory bus (MemRead / MemWrite / Address / Write_Data) and drives Read_Data back to it.
- Sits beside data memory. The top-level address decoder muxes Read_Data into the CPU's Device_Read_Data whenever Address falls in this block's window.
- Contains:
  - a reloadable timer with interrupt,
  - a free-running systick counter,
  - an LED register,
  - a seven-segment digit register.

Parameters:
- BASE_ADDR, 32'h4000_0000, start of the 32-byte register window; must be 32-byte aligned.
- PRESCALE, 1, number of clk cycles per timer increment; legal range 1..65535.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- MemRead, input, 1, CPU load strobe, MEM stage.
- MemWrite, input, 1, CPU store strobe, MEM stage.
- Address, input, 32, byte address from the CPU.
- Write_Data, input, 32, store data.
- Read_Data, output, 32, load data; combinational.
- leds, output, 8, LED register contents.
- digits, output, 12, seven-segment register: [11:8] anode select, [7:0] segments.
- irq, output, 1, timer interrupt request, level-sensitive.

Behaviour:
- Register map, as offsets from BASE_ADDR:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON[2:0]: bit0 enable, bit1 irq enable, bit2 irq status; R/W, upper bits read 0.
  - 0x0C LED[7:0]: R/W.
  - 0x10 DIGITS[11:0]: R/W.
  - 0x14 SYSTICK: read-only.
  - 0x18, 0x1C: unmapped.
- Hit = (Address[31:5] == BASE_ADDR[31:5]). Register index = Address[4:2]. Address[1:0] is ignored; the bus is word-only.
- Read:
  - Read_Data = selected register when MemRead && hit, else 32'h0.
  - Unmapped offsets return 0.
  - Latency is 0 cycles (combinational).
- Write:
  - When MemWrite && hit, the register takes Write_Data at the next clk edge.
  - Writes to SYSTICK and to unmapped offsets are ignored.
  - When both MemRead and MemWrite are high, the write occurs and Read_Data shows the pre-write value.
- Reset (reset=0, asynchronous): TH, TL, TCON, LED, DIGITS, SYSTICK, prescale counter = 0. Therefore irq=0, leds=0, digits=0.
- SYSTICK increments by 1 every cycle after reset and wraps 32'hFFFF_FFFF -> 0.
- Prescaler:
  - 16-bit counter pc runs only while TCON[0]=1.
  - tick = (pc == PRESCALE-1); on tick, pc returns to 0.
  - Clearing TCON[0] freezes pc at its current value; it is not cleared.
- Timer state machine, two states:
  - IDLE (TCON[0]=0): TL holds its value.
  - RUN (TCON[0]=1): on tick, TL increments. If TL == 32'hFFFF_FFFF at the tick, TL <= TH instead of wrapping to 0, and TCON[2] <= 1 if TCON[1]=1.
- irq = TCON[1] & TCON[2], driven directly from registers (no added delay).
- Simultaneous CPU write and timer update in the same cycle:
  - A CPU write to TL overrides both increment and reload.
  - A CPU write to TCON overrides the hardware set of bit2; software clears status by writing bit2=0.
  - A write to TH in the overflow cycle: the reload uses the old TH.
- Reset asserted mid-count: all state clears immediately, with no wait for a clk edge.

Decomposition:
- Package mmio_pkg holds:
  - register offset constants (OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_DIGITS, OFF_SYSTICK),
  - TCON bit positions (TCON_EN=0, TCON_IE=1, TCON_IF=2),
  - the default BASE_ADDR.
- One sub-module, mmio_timer_core, containing the prescaler, TL/TH update logic and the overflow flag. It receives decoded write enables plus data, and outputs TL, TH, TCON.
- The top level keeps the address decode, the read mux, LED/DIGITS/SYSTICK registers, and irq.

Test Plan:
- Reset, then MemRead at 0x4000_0014 for 5 consecutive cycles -> Read_Data = 0,1,2,3,4 (±1 in the first cycle only, depending on reset-release alignment); all other registers read 0; irq=0.
- Write TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3 with PRESCALE=1 -> TL reads FFFF_FFFF, then FFFF_FFF0; TCON reads 7 and irq=1 in the cycle after the reload.
- With irq=1, write TCON=3 -> irq=0 the next cycle. In the same cycle as an overflow, TCON write of 3 wins and bit2 stays 0.
- PRESCALE=4, TL=0, TCON=1 -> after 12 cycles TL=3. Clear TCON[0] -> TL stays 3 for 20 cycles.
- Write LED=0x1A5 and DIGITS=0xF7E3 -> leds=0xA5, digits=0x7E3, and readback matches. MemWrite at 0x4000_0018 or 0x5000_000C -> no state change, and reads return 0.
- Assert reset low mid-count, between clk edges -> every output and register is 0 immediately; TL does not resume counting until TCON is rewritten.
